wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
//
// PURPOSE
// - Sole driver of the register file write port (WEN/wsel/wdat).
// - Merges two write sources:
//   - in-order pipeline writeback, which never stalls;
//   - long-latency unit (mul/div) results, via valid/ready handshake.
// - Conflicting long-unit results wait in a small FIFO and drain on idle writeback cycles.
// - Reports pending destination registers so decode can stall on RAW hazards.
//
// PARAMETERS
// - DEPTH  4   long-unit result FIFO entries (power of 2, >=2)
//
// PORTS
// - CLK          in   1   clock, rising edge
// - RST          in   1   asynchronous reset, active-high
// - wb_valid     in   1   pipeline writeback this cycle
// - wb_wsel      in   5   pipeline destination register
// - wb_wdat      in   32  pipeline write data
// - lu_valid     in   1   long-unit result offered
// - lu_wsel      in   5   long-unit destination register
// - lu_wdat      in   32  long-unit result data
// - lu_ready     out  1   result accepted this cycle (lu_valid & lu_ready)
// - pend_rsel1   in   5   decode source reg 1 query
// - pend_rsel2   in   5   decode source reg 2 query
// - pend_hit1    out  1   rsel1 has a buffered, unwritten result
// - pend_hit2    out  1   rsel2 has a buffered, unwritten result
// - rf_WEN       out  1   register file write enable (registered)
// - rf_wsel      out  5   register file write select (registered)
// - rf_wdat      out  32  register file write data (registered)
//
// BEHAVIOUR
// Reset (RST high, asynchronous):
// - FIFO empty, pointers 0.
// - rf_WEN/rf_wsel/rf_wdat = 0.
// - lu_ready = 0 while RST is high; pend_hit1/2 = 0.
//
// Per-cycle selection, in priority order:
// 1. wb_valid: forward wb_* to rf_* at the next edge (latency 1).
// 2. Else FIFO non-empty: pop the head entry to rf_*.
// 3. Else lu_valid & lu_ready: forward lu_* directly (bypass, latency 1, no FIFO entry).
// 4. Else rf_WEN = 0 next cycle; rf_wsel/rf_wdat hold their previous values.
//
// FIFO rules:
// - An accepted lu result that is not forwarded this cycle is pushed.
// - lu_ready = !full.
// - When full, a same-cycle pop does not raise lu_ready (no combinational pop->ready path).
// - Simultaneous push and pop on a non-empty FIFO: occupancy unchanged; pointers wrap modulo DEPTH.
//
// Register $0:
// - Any source with wsel==0 is consumed normally (handshake, FIFO slot) but rf_WEN stays 0 for it.
// - pend_hit is never set for register 0.
//
// Ordering (WAW):
// - Pipeline writebacks are younger than any buffered long-unit result.
// - A pipeline write with wb_wsel==R invalidates every valid FIFO entry with wsel==R.
// - Invalidated entries still pop in order but produce rf_WEN = 0.
//
// pend_hit:
// - pend_hitN = OR over valid, non-invalidated FIFO entries of (wsel==pend_rselN).
// - Purely combinational from state; excludes the entry currently driving rf_*.
//
// Mid-operation reset: all buffered results are discarded; no write is issued.
//
// CONFIGURATION
// - Macro WB_ARB_STATS_EN.
// - Defined:
//   - adds output stat_conflicts [15:0];
//   - increments on every cycle with wb_valid & lu_valid (bypass denied);
//   - saturates at 16'hFFFF; reset to 0.
// - Undefined: port and counter are absent; all other behaviour is identical.
//
// TESTING
// - Isolated pipeline write: wb_valid=1, wb_wsel=5, wb_wdat=32'hDEADBEEF
//   -> next cycle rf_WEN=1, rf_wsel=5, rf_wdat=DEADBEEF.
// - Conflict: wb(3,32'h11) and lu(7,32'h22) same cycle, then idle
//   -> rf writes r3 first, r7 next cycle; pend_hit for r7 high for exactly one cycle.
// - Fill: wb_valid held high with 5 lu results offered, DEPTH=4
//   -> 4 accepted, lu_ready=0 on the 5th; drain order preserved after wb_valid drops.
// - WAW squash: buffered lu(9,32'hAA), then wb(9,32'hBB)
//   -> r9 written BB only; popped entry gives rf_WEN=0.
// - $0 and reset: lu(0,x) -> rf_WEN stays 0.
//   RST asserted with 2 entries buffered -> FIFO empty, outputs 0, no write after release.
// - WB_ARB_STATS_EN: 3 conflict cycles -> stat_conflicts=3; counter saturates at FFFF.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register file write-port arbiter.
// Merges the never-stalling pipeline writeback with long-latency unit results.
// Long-unit results that lose arbitration are parked in a small FIFO.
// The FIFO drains on idle writeback cycles.
// Optional macro WB_ARB_STATS_EN adds a saturating conflict counter on stat_conflicts.
module wb_write_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wb_valid,
    input  logic [4:0]  wb_wsel,
    input  logic [31:0] wb_wdat,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wsel,
    input  logic [31:0] lu_wdat,
    output logic        lu_ready,
    input  logic [4:0]  pend_rsel1,
    input  logic [4:0]  pend_rsel2,
    output logic        pend_hit1,
    output logic        pend_hit2,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
`ifdef WB_ARB_STATS_EN
    output logic [15:0] stat_conflicts,
`endif
    output logic [31:0] rf_wdat
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // FIFO storage; live marks an occupied entry that has not been squashed by a younger write
    logic [4:0]       wsel_q [DEPTH];
    logic [4:0]       wsel_d [DEPTH];
    logic [31:0]      wdat_q [DEPTH];
    logic [31:0]      wdat_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             rf_wen_q, rf_wen_d;
    logic [4:0]       rf_wsel_q, rf_wsel_d;
    logic [31:0]      rf_wdat_q, rf_wdat_d;

    logic             full, empty, accept, push, pop;

`ifdef WB_ARB_STATS_EN
    logic [15:0]      stat_q, stat_d;
`endif

    // Ready depends only on stored occupancy, so a pop never raises ready in the same cycle
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        lu_ready = !full && !RST;
        accept   = lu_valid && lu_ready;
    end

    // Source selection, FIFO pointer/occupancy update and WAW squash
    always_comb begin
        wsel_d    = wsel_q;
        wdat_d    = wdat_q;
        live_d    = live_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rf_wen_d  = 1'b0;
        rf_wsel_d = rf_wsel_q;
        rf_wdat_d = rf_wdat_q;
        push      = 1'b0;
        pop       = 1'b0;

        if (wb_valid) begin
            rf_wen_d  = (wb_wsel != 5'd0);
            rf_wsel_d = wb_wsel;
            rf_wdat_d = wb_wdat;
            push      = accept;
        end else if (!empty) begin
            pop       = 1'b1;
            rf_wen_d  = live_q[rd_ptr_q] && (wsel_q[rd_ptr_q] != 5'd0);
            rf_wsel_d = wsel_q[rd_ptr_q];
            rf_wdat_d = wdat_q[rd_ptr_q];
            push      = accept;
        end else if (accept) begin
            rf_wen_d  = (lu_wsel != 5'd0);
            rf_wsel_d = lu_wsel;
            rf_wdat_d = lu_wdat;
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wsel_d[wr_ptr_q] = lu_wsel;
            wdat_d[wr_ptr_q] = lu_wdat;
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        // A pipeline write is younger than anything buffered, including a same-cycle push
        if (wb_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wsel_d[i] == wb_wsel) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

`ifdef WB_ARB_STATS_EN
    // Saturating count of cycles where a long-unit result was denied the bypass
    always_comb begin
        stat_d = stat_q;
        if (wb_valid && lu_valid && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    assign stat_conflicts = stat_q;
`endif

    // State registers; reset discards all buffered results
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                wsel_q[i] <= '0;
                wdat_q[i] <= '0;
            end
            live_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rf_wen_q  <= 1'b0;
            rf_wsel_q <= '0;
            rf_wdat_q <= '0;
`ifdef WB_ARB_STATS_EN
            stat_q    <= '0;
`endif
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                wsel_q[i] <= wsel_d[i];
                wdat_q[i] <= wdat_d[i];
            end
            live_q    <= live_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rf_wen_q  <= rf_wen_d;
            rf_wsel_q <= rf_wsel_d;
            rf_wdat_q <= rf_wdat_d;
`ifdef WB_ARB_STATS_EN
            stat_q    <= stat_d;
`endif
        end
    end

    // RAW hazard lookup over live buffered entries; register 0 never reports pending
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (live_q[i] && (wsel_q[i] == pend_rsel1) && (pend_rsel1 != 5'd0)) begin
                pend_hit1 = 1'b1;
            end
            if (live_q[i] && (wsel_q[i] == pend_rsel2) && (pend_rsel2 != 5'd0)) begin
                pend_hit2 = 1'b1;
            end
        end
    end

    assign rf_WEN  = rf_wen_q;
    assign rf_wsel = rf_wsel_q;
    assign rf_wdat = rf_wdat_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-based reference model plus directed vectors.
module tb_wb_write_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        CLK, RST;
    logic        wb_valid, lu_valid, lu_ready;
    logic [4:0]  wb_wsel, lu_wsel, pend_rsel1, pend_rsel2, rf_wsel;
    logic [31:0] wb_wdat, lu_wdat, rf_wdat;
    logic        pend_hit1, pend_hit2, rf_WEN;
`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_conflicts;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 0;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .wb_valid(wb_valid), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .lu_valid(lu_valid), .lu_wsel(lu_wsel), .lu_wdat(lu_wdat),
        .lu_ready(lu_ready),
        .pend_rsel1(pend_rsel1), .pend_rsel2(pend_rsel2),
        .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel),
`ifdef WB_ARB_STATS_EN
        .stat_conflicts(stat_conflicts),
`endif
        .rf_wdat(rf_wdat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered results as an ordered queue
    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] wdat;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e;
    logic        m_wen;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;
    logic [15:0] m_stat;
    bit          m_acc;

    function automatic logic exp_pend(input logic [4:0] r);
        exp_pend = 1'b0;
        if (r != 5'd0)
            foreach (mq[i]) if (mq[i].live && mq[i].wsel == r) exp_pend = 1'b1;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_stat = '0;
        end else begin
            m_acc = lu_valid && (mq.size() < DEPTH);
            if (wb_valid && lu_valid && m_stat != 16'hFFFF) m_stat = m_stat + 16'd1;
            if (wb_valid) begin
                m_wen = (wb_wsel != 0); m_wsel = wb_wsel; m_wdat = wb_wdat;
                if (m_acc) mq.push_back('{lu_wsel, lu_wdat, 1'b1});
                foreach (mq[i]) if (mq[i].wsel == wb_wsel) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                m_e = mq.pop_front();
                m_wen = m_e.live && (m_e.wsel != 0); m_wsel = m_e.wsel; m_wdat = m_e.wdat;
                if (m_acc) mq.push_back('{lu_wsel, lu_wdat, 1'b1});
            end else if (m_acc) begin
                m_wen = (lu_wsel != 0); m_wsel = lu_wsel; m_wdat = lu_wdat;
            end else begin
                m_wen = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_rf_WEN",    32'(rf_WEN),    32'(m_wen));
            chk("m_rf_wsel",   32'(rf_wsel),   32'(m_wsel));
            chk("m_rf_wdat",   rf_wdat,        m_wdat);
            chk("m_lu_ready",  32'(lu_ready),  32'(!RST && mq.size() < DEPTH));
            chk("m_pend_hit1", 32'(pend_hit1), 32'(exp_pend(pend_rsel1)));
            chk("m_pend_hit2", 32'(pend_hit2), 32'(exp_pend(pend_rsel2)));
`ifdef WB_ARB_STATS_EN
            chk("m_stat",      32'(stat_conflicts), 32'(m_stat));
`endif
        end
    end

    task automatic set_in(input logic wv, input logic [4:0] ws, input logic [31:0] wd,
                          input logic lv, input logic [4:0] ls, input logic [31:0] ld);
        wb_valid = wv; wb_wsel = ws; wb_wdat = wd;
        lu_valid = lv; lu_wsel = ls; lu_wdat = ld;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        pend_rsel1 = 5'd0; pend_rsel2 = 5'd0;
        RST = 1'b0;
        #2 RST = 1'b1;
        tick(); tick();
        chk_en = 1;
        chk("rst_wen",   32'(rf_WEN),   32'd0);
        chk("rst_wdat",  rf_wdat,       32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd0);
        RST = 1'b0;
        #1 chk("post_rst_ready", 32'(lu_ready), 32'd1);

        // Isolated pipeline write
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick(); idle();
        chk("iso_wen",  32'(rf_WEN),  32'd1);
        chk("iso_wsel", 32'(rf_wsel), 32'd5);
        chk("iso_wdat", rf_wdat,      32'hDEADBEEF);
        tick();
        chk("iso_idle_wen",  32'(rf_WEN),  32'd0);
        chk("iso_hold_wsel", 32'(rf_wsel), 32'd5);

        // Same-cycle conflict: r3 first, r7 next, pend for r7 for one cycle
        set_in(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        pend_rsel1 = 5'd7;
        #1 chk("cf_pend_before", 32'(pend_hit1), 32'd0);
        tick(); idle();
        #1;
        chk("cf_wsel0", 32'(rf_wsel),   32'd3);
        chk("cf_wdat0", rf_wdat,        32'h11);
        chk("cf_pend",  32'(pend_hit1), 32'd1);
        tick();
        #1;
        chk("cf_wen1",  32'(rf_WEN),    32'd1);
        chk("cf_wsel1", 32'(rf_wsel),   32'd7);
        chk("cf_wdat1", rf_wdat,        32'h22);
        chk("cf_pend1", 32'(pend_hit1), 32'd0);
        tick();
        chk("cf_idle", 32'(rf_WEN), 32'd0);

        // Fill: 4 accepted, 5th refused, drain in order
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 5'(k + 1), 32'(100 + k), 1'b1, 5'(10 + k), 32'(200 + k));
            #1 chk("fill_ready", 32'(lu_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        #1 chk("full_pop_ready", 32'(lu_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_wen",  32'(rf_WEN),  32'd1);
            chk("drain_wsel", 32'(rf_wsel), 32'(10 + k));
            chk("drain_wdat", rf_wdat,      32'(200 + k));
        end
        tick();
        chk("drain_done", 32'(rf_WEN), 32'd0);

        // WAW squash of buffered r9
        set_in(1'b1, 5'd1, 32'd1, 1'b1, 5'd9, 32'hAA);
        pend_rsel1 = 5'd9;
        tick();
        set_in(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0);
        #1 chk("waw_pend", 32'(pend_hit1), 32'd1);
        tick(); idle();
        #1;
        chk("waw_wen",  32'(rf_WEN),    32'd1);
        chk("waw_wsel", 32'(rf_wsel),   32'd9);
        chk("waw_wdat", rf_wdat,        32'hBB);
        chk("waw_pend_clr", 32'(pend_hit1), 32'd0);
        tick();
        chk("waw_squash", 32'(rf_WEN), 32'd0);
        tick();

        // Register 0 is consumed but never written or reported
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        tick(); idle();
        chk("r0_bypass", 32'(rf_WEN), 32'd0);
        set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd0, 32'h66);
        tick(); idle();
        pend_rsel1 = 5'd0;
        #1;
        chk("r0_pend",  32'(pend_hit1), 32'd0);
        chk("r0_wb2",   32'(rf_wsel),   32'd2);
        tick();
        chk("r0_pop", 32'(rf_WEN), 32'd0);

        // Mid-operation reset with two entries buffered
        set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'h0B);
        tick();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'h0C);
        tick(); idle();
        pend_rsel1 = 5'd11; pend_rsel2 = 5'd12;
        #1 chk("mr_pend_pre", 32'(pend_hit1), 32'd1);
        RST = 1'b1;
        #1;
        chk("mr_wen",   32'(rf_WEN),    32'd0);
        chk("mr_wsel",  32'(rf_wsel),   32'd0);
        chk("mr_wdat",  rf_wdat,        32'd0);
        chk("mr_ready", 32'(lu_ready),  32'd0);
        chk("mr_pend",  32'(pend_hit2), 32'd0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_nowrite", 32'(rf_WEN), 32'd0);
        end

`ifdef WB_ARB_STATS_EN
        chk("st_zero", 32'(stat_conflicts), 32'd0);
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 5'(k + 1), 32'(k), 1'b1, 5'(20 + k), 32'(k));
            tick();
        end
        idle();
        chk("st_three", 32'(stat_conflicts), 32'd3);
        set_in(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2);
        repeat (65540) tick();
        chk("st_sat", 32'(stat_conflicts), 32'hFFFF);
        idle();
        repeat (6) tick();
`endif

        // Mixed traffic over a small register range to exercise WAW, $0 and backpressure
        for (int k = 0; k < 400; k++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            pend_rsel1 = 5'($urandom_range(0, 3));
            pend_rsel2 = 5'($urandom_range(0, 3));
            tick();
        end
        idle();
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
